// File: rtl/musa_stack_pkg.sv
// rtl/musa_stack_pkg.sv - shared types and defaults for the return-address stack control path
package musa_stack_pkg;

   // Program-counter width of the core; the attached stack uses the same width.
   localparam int PC_W_DEFAULT = 18;

   // Sequencing states of the call/return controller.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PUSH     = 3'd1,
      S_POP      = 3'd2,
      S_POP_WAIT = 3'd3,
      S_ERR      = 3'd4,
      S_DONE     = 3'd5
   } ras_state_t;

endpackage

// File: rtl/stack_depth_ctr.sv
// rtl/stack_depth_ctr.sv - saturating up/down occupancy counter for the return-address stack
module stack_depth_ctr #(
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

   assign full  = (count == MAX_CNT);
   assign empty = (count == '0);

   // Count moves by one per strobe and clamps at both ends so it can never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !empty) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ras_call_ctrl.sv
// rtl/ras_call_ctrl.sv - turns call/return requests into timed push/pop strobes and a redirect PC
import musa_stack_pkg::*;

module ras_call_ctrl #(
   parameter int PC_W  = PC_W_DEFAULT,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             call_req,
   input  logic [PC_W-1:0]  call_ret_addr,
   input  logic [PC_W-1:0]  call_target,
   input  logic             ret_req,
   output logic             busy,
   output logic             done,
   output logic [PC_W-1:0]  next_pc,
   output logic             next_pc_valid,
   output logic             ovf_err,
   output logic             unf_err,
   output logic [CNT_W-1:0] depth,
   output logic             stk_push,
   output logic             stk_pop,
   output logic [PC_W-1:0]  stk_din,
   input  logic [PC_W-1:0]  stk_dout
);

   ras_state_t      state;
   logic [PC_W-1:0] result;
   logic [PC_W-1:0] din_q;
   logic            err_is_ovf;
   logic            full;
   logic            empty;

   stack_depth_ctr #(
      .DEPTH (DEPTH)
   ) u_depth (
      .clk   (clk),
      .reset (reset),
      .inc   (stk_push),
      .dec   (stk_pop),
      .count (depth),
      .full  (full),
      .empty (empty)
   );

   // Requests are only looked at in IDLE; returns win ties so the call stays pending for the next IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         result     <= '0;
         din_q      <= '0;
         err_is_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ret_req) begin
                  err_is_ovf <= 1'b0;
                  state      <= empty ? S_ERR : S_POP;
               end else if (call_req) begin
                  err_is_ovf <= 1'b1;
                  din_q      <= call_ret_addr;
                  result     <= call_target;
                  state      <= full ? S_ERR : S_PUSH;
               end
            end
            S_PUSH:     state <= S_DONE;
            S_POP:      state <= S_POP_WAIT;
            S_POP_WAIT: begin
               result <= stk_dout;
               state  <= S_DONE;
            end
            S_DONE:     state <= S_IDLE;
            S_ERR:      state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

   // Every output is a pure decode of state or a register, keeping inputs off all output paths.
   assign busy          = (state != S_IDLE);
   assign stk_push      = (state == S_PUSH);
   assign stk_pop       = (state == S_POP);
   assign done          = (state == S_DONE) || (state == S_ERR);
   assign next_pc_valid = (state == S_DONE);
   assign ovf_err       = (state == S_ERR) &&  err_is_ovf;
   assign unf_err       = (state == S_ERR) && !err_is_ovf;
   assign next_pc       = result;
   assign stk_din       = din_q;

endmodule

// File: tb/tb_ras_call_ctrl.sv
// tb/tb_ras_call_ctrl.sv - directed self-checking bench for ras_call_ctrl with a behavioural stack
module tb_ras_call_ctrl;

   localparam int PC_W  = 18;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             call_req;
   logic [PC_W-1:0]  call_ret_addr;
   logic [PC_W-1:0]  call_target;
   logic             ret_req;
   logic             busy;
   logic             done;
   logic [PC_W-1:0]  next_pc;
   logic             next_pc_valid;
   logic             ovf_err;
   logic             unf_err;
   logic [CNT_W-1:0] depth;
   logic             stk_push;
   logic             stk_pop;
   logic [PC_W-1:0]  stk_din;
   logic [PC_W-1:0]  stk_dout;

   int tests_run = 0;
   int tests_failed = 0;

   ras_call_ctrl #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .call_req      (call_req),
      .call_ret_addr (call_ret_addr),
      .call_target   (call_target),
      .ret_req       (ret_req),
      .busy          (busy),
      .done          (done),
      .next_pc       (next_pc),
      .next_pc_valid (next_pc_valid),
      .ovf_err       (ovf_err),
      .unf_err       (unf_err),
      .depth         (depth),
      .stk_push      (stk_push),
      .stk_pop       (stk_pop),
      .stk_din       (stk_din),
      .stk_dout      (stk_dout)
   );

   always #5 clk = ~clk;

   // Behavioural LIFO standing in for the real stack: read data registered one cycle after pop.
   logic [PC_W-1:0] mem [DEPTH];
   int sp;
   always @(posedge clk) begin
      if (reset) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_push && sp < DEPTH) begin
         mem[sp] <= stk_din;
         sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_dout <= mem[sp-1];
         sp       <= sp - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Protocol watchers, sampled on the falling edge away from state updates.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (stk_push && stk_pop) check("push_pop_excl", 32'(stk_push & stk_pop), 32'd0);
         if (stk_push || stk_pop || done) check("busy_when_active", 32'(busy), 32'd1);
         if (done && prev_done) check("done_single_cycle", 32'(prev_done & done), 32'd0);
      end
      prev_done <= done;
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; call_req = 1'b0; ret_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_call(input logic [PC_W-1:0] ra, input logic [PC_W-1:0] tg,
                          input bit exp_ovf, input int exp_depth);
      @(negedge clk);
      call_req = 1'b1; call_ret_addr = ra; call_target = tg;
      @(negedge clk);
      if (exp_ovf) begin
         check("ovf_done", 32'(done), 32'd1);
         check("ovf_flag", 32'(ovf_err), 32'd1);
         check("ovf_no_push", 32'(stk_push), 32'd0);
         check("ovf_npc_valid", 32'(next_pc_valid), 32'd0);
         call_req = 1'b0;
         @(negedge clk);
         check("ovf_depth", 32'(depth), 32'(exp_depth));
      end else begin
         check("call_push", 32'(stk_push), 32'd1);
         check("call_din", 32'(stk_din), 32'(ra));
         check("call_not_done_early", 32'(done), 32'd0);
         @(negedge clk);
         check("call_done", 32'(done), 32'd1);
         check("call_npc_valid", 32'(next_pc_valid), 32'd1);
         check("call_next_pc", 32'(next_pc), 32'(tg));
         check("call_depth", 32'(depth), 32'(exp_depth));
         call_req = 1'b0;
      end
   endtask

   task automatic do_ret(input bit exp_unf, input logic [PC_W-1:0] exp_pc, input int exp_depth);
      @(negedge clk);
      ret_req = 1'b1;
      @(negedge clk);
      if (exp_unf) begin
         check("unf_done", 32'(done), 32'd1);
         check("unf_flag", 32'(unf_err), 32'd1);
         check("unf_npc_valid", 32'(next_pc_valid), 32'd0);
         check("unf_no_pop", 32'(stk_pop), 32'd0);
         ret_req = 1'b0;
         @(negedge clk);
         check("unf_depth", 32'(depth), 32'(exp_depth));
      end else begin
         check("ret_pop", 32'(stk_pop), 32'd1);
         @(negedge clk);
         check("ret_wait_no_pop", 32'(stk_pop), 32'd0);
         check("ret_wait_not_done", 32'(done), 32'd0);
         @(negedge clk);
         check("ret_done", 32'(done), 32'd1);
         check("ret_npc_valid", 32'(next_pc_valid), 32'd1);
         check("ret_next_pc", 32'(next_pc), 32'(exp_pc));
         check("ret_depth", 32'(depth), 32'(exp_depth));
         ret_req = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; call_req = 1'b0; ret_req = 1'b0;
      call_ret_addr = '0; call_target = '0;
      do_reset();

      // Reset state.
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_depth", 32'(depth), 32'd0);
      check("rst_next_pc", 32'(next_pc), 32'd0);
      check("rst_stk_din", 32'(stk_din), 32'd0);

      // Single call then return.
      do_call(18'h00123, 18'h3F000, 1'b0, 1);
      do_ret(1'b0, 18'h00123, 0);

      // Return on empty after reset.
      do_reset();
      do_ret(1'b1, '0, 0);

      // LIFO order and overflow.
      for (int i = 1; i <= 4; i++)
         do_call(18'(i * 16), 18'h20000 + 18'(i), 1'b0, i);
      do_call(18'h00050, 18'h20005, 1'b1, 4);
      for (int i = 4; i >= 1; i--)
         do_ret(1'b0, 18'(i * 16), i - 1);

      // Simultaneous requests: return first, call served next.
      do_call(18'h0AAAA, 18'h01111, 1'b0, 1);
      @(negedge clk);
      call_req = 1'b1; call_ret_addr = 18'h0BBBB; call_target = 18'h12345;
      ret_req = 1'b1;
      @(negedge clk);
      check("sim_pop_first", 32'(stk_pop), 32'd1);
      check("sim_no_push", 32'(stk_push), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("sim_ret_done", 32'(done), 32'd1);
      check("sim_ret_pc", 32'(next_pc), 32'h0AAAA);
      check("sim_ret_depth", 32'(depth), 32'd0);
      ret_req = 1'b0;
      @(negedge clk);
      check("sim_call_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("sim_call_push", 32'(stk_push), 32'd1);
      check("sim_call_din", 32'(stk_din), 32'h0BBBB);
      @(negedge clk);
      check("sim_call_done", 32'(done), 32'd1);
      check("sim_call_pc", 32'(next_pc), 32'h12345);
      check("sim_call_depth", 32'(depth), 32'd1);
      call_req = 1'b0;

      // Reset during POP_WAIT.
      @(negedge clk);
      ret_req = 1'b1;
      @(negedge clk);
      check("mid_pop", 32'(stk_pop), 32'd1);
      @(negedge clk);
      reset = 1'b1; ret_req = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_npcv", 32'(next_pc_valid), 32'd0);
      check("mid_rst_errs", 32'({ovf_err, unf_err}), 32'd0);
      check("mid_rst_strobes", 32'({stk_push, stk_pop}), 32'd0);
      check("mid_rst_next_pc", 32'(next_pc), 32'd0);
      check("mid_rst_stk_din", 32'(stk_din), 32'd0);
      check("mid_rst_depth", 32'(depth), 32'd0);
      reset = 1'b0;
      do_ret(1'b1, '0, 0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/ras_call_ctrl.md
# ras_call_ctrl

Sequencing controller for the core's 18-bit return-address stack (`stack`). It accepts call and return requests from the branch/decode stage and converts each into correctly timed single-cycle push/pop strobes, then returns the next PC: the call target, or the popped return address. It also keeps the logical stack depth, blocks overflow and underflow, and stalls the pipeline while a request is in flight.

## Interface
- `PC_W`, 18, program-counter width; must match the stack instance.
- `DEPTH`, 16, number of entries in the attached stack; `CNT_W = $clog2(DEPTH+1)`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; the same reset also drives the stack.
- `call_req`  in  1  call request; held high until `done`.
- `call_ret_addr`  in  PC_W  return address to save (PC+1); stable while `call_req` is high.
- `call_target`  in  PC_W  jump target; stable while `call_req` is high.
- `ret_req`  in  1  return request; held high until `done`.
- `busy`  out  1  stall to the pipeline.
- `done`  out  1  one-cycle completion pulse.
- `next_pc`  out  PC_W  redirect PC; valid only when `next_pc_valid` is high.
- `next_pc_valid`  out  1  pulse, coincident with `done` for successful operations.
- `ovf_err`  out  1  pulse with `done`: call was rejected because the stack is full.
- `unf_err`  out  1  pulse with `done`: return was rejected because the stack is empty.
- `depth`  out  CNT_W  current number of valid entries.
- `stk_push`  out  1  to stack `push`.
- `stk_pop`  out  1  to stack `pop`.
- `stk_din`  out  PC_W  to stack `read_PC` (data to push).
- `stk_dout`  in  PC_W  from stack `write_PC`; valid the cycle after `stk_pop`.

## Operation
States: IDLE, PUSH, POP, POP_WAIT, ERR, DONE.
- **IDLE**
  - Requests are sampled only in this state.
  - `ret_req` has priority over `call_req` when both are high. The losing request stays pending and is served after the current request completes.
  - `ret_req` with `depth==0` → ERR (underflow).
  - `ret_req` otherwise → POP.
  - `call_req` with `depth==DEPTH` → ERR (overflow).
  - `call_req` otherwise → PUSH.
  - On acceptance, latch `call_ret_addr` into `stk_din` and `call_target` into the result register.
- **PUSH**
  - `stk_push=1` for exactly one cycle.
  - `depth` increments at the end of the cycle.
  - → DONE.
- **POP**
  - `stk_pop=1` for exactly one cycle.
  - `depth` decrements.
  - → POP_WAIT.
- **POP_WAIT**
  - Capture `stk_dout` into the result register.
  - → DONE.
- **DONE**
  - `done=1` and `next_pc_valid=1`; `next_pc` = result register.
  - → IDLE.
- **ERR**
  - `done=1` with either `ovf_err=1` or `unf_err=1`.
  - `next_pc_valid=0`; no strobe to the stack; `depth` unchanged.
  - → IDLE.
- `busy=1` in every state except IDLE.
- `stk_push` and `stk_pop` are never high in the same cycle.
- `depth` saturates in `[0, DEPTH]` and never wraps.
- Requester rule: drop the request on the clock edge that ends the `done` cycle. A request still high in IDLE is treated as a new request.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Request seen in IDLE at cycle T:
  - Call: `stk_push` at T+1; `done`/`next_pc_valid` at T+2.
  - Return: `stk_pop` at T+1; `stk_dout` sampled at T+2; `done` at T+3.
  - Error: `done` plus error flag at T+1.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle following DONE/ERR.
- Reset (any state, including mid-PUSH/POP):
  - Next cycle is IDLE, `depth=0`.
  - `busy`, `done`, `next_pc_valid`, `ovf_err`, `unf_err`, `stk_push`, `stk_pop` = 0.
  - `next_pc` and `stk_din` = 0.
  - Pending requests are discarded.

## Structure
- Shared package `musa_stack_pkg`:
  - `PC_W` default.
  - `ras_state_t` enum (IDLE, PUSH, POP, POP_WAIT, ERR, DONE).
- One sub-module, `stack_depth_ctr`:
  - Saturating up/down counter with `inc`, `dec`, `full`, `empty`, `count` outputs.
  - Parameterised by `DEPTH`.
- The stack itself is instantiated beside this block, not inside it.

## Test plan
Each scenario uses `DEPTH=4` with a real `stack` instance attached.
1. **Single call then return.** Call with `call_ret_addr=18'h00123`, `call_target=18'h3F000`: `stk_push` at T+1, `next_pc=18'h3F000` at T+2, `depth=1`. Then a return: `next_pc=18'h00123` at T+3, `depth=0`.
2. **LIFO order.** Five calls with return addresses `18'h00010`…`18'h00050`: the fifth call gives `ovf_err=1`, no push, `depth` stays 4. Four returns then yield `18'h00040`, `18'h00030`, `18'h00020`, `18'h00010`.
3. **Return on empty.** `ret_req` after reset: `done` and `unf_err` at T+1, `next_pc_valid=0`, `stk_pop` never asserted.
4. **Simultaneous requests.** `call_req` and `ret_req` both high with `depth=1`: the return is served first and pops the stored address; the call is served next and `depth` returns to 1.
5. **Reset mid-operation.** Assert `reset` in the POP_WAIT cycle: next cycle all outputs are 0 and `depth=0`. A subsequent return gives `unf_err`.
6. **Protocol checks.** Assertions: `stk_push` and `stk_pop` are never both high; `busy` is high in every non-IDLE cycle; `done` lasts one cycle per request.
